dense_controller: RTL and testbench

- FSM that sequences the dense-layer datapath: clears counters and accumulator, runs the multiply-accumulate over all inputs of one output, adds the bias, writes the result, and repeats for all outputs.
- Sits between the layer-level scheduler (start/done handshake), the datapath control/status pins and the AXIS buffer flow-control flags.
- Keeps shadow beat counters and flags protocol errors when datapath status disagrees with the expected count.

---
 rtl/dense_controller.sv | 142 ++++++++++++++
 tb/tb_dense_controller.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dense_controller.sv
// Sequencer for one dense layer: clears the datapath, streams IN_COUNT MAC beats per neuron,
// adds the bias, writes each result, and repeats for OUT_COUNT neurons while cross-checking status.
module dense_controller #(
  parameter int IN_COUNT  = 16,
  parameter int OUT_COUNT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  output logic err,
  input  logic bufInValid,
  input  logic bufOutReady,
  output logic bufOutWr,
  output logic clear,
  output logic inCntEn,
  output logic clearReg,
  output logic WorB,
  output logic load,
  output logic outCntEn,
  input  logic mulDone,
  input  logic calcDone
);

  localparam int IW = $clog2(IN_COUNT) + 1;
  localparam int OW = $clog2(OUT_COUNT) + 1;
  localparam logic [IW-1:0] IN_LAST  = IW'(IN_COUNT - 1);
  localparam logic [OW-1:0] OUT_LAST = OW'(OUT_COUNT - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    MAC  = 3'd2,
    BIAS = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [IW-1:0] in_cnt;
  logic [IW-1:0] in_cnt_next;
  logic [OW-1:0] out_cnt;
  logic [OW-1:0] out_cnt_next;
  logic          err_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      in_cnt  <= '0;
      out_cnt <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_next;
      in_cnt  <= in_cnt_next;
      out_cnt <= out_cnt_next;
      err     <= err_next;
    end
  end

  always_comb begin
    state_next   = state;
    in_cnt_next  = in_cnt;
    out_cnt_next = out_cnt;
    err_next     = err;
    busy         = 1'b1;
    done         = 1'b0;
    clear        = 1'b0;
    clearReg     = 1'b0;
    inCntEn      = 1'b0;
    load         = 1'b0;
    WorB         = 1'b0;
    bufOutWr     = 1'b0;
    outCntEn     = 1'b0;

    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = INIT;
          err_next   = 1'b0;
        end
      end

      INIT: begin
        clear        = 1'b1;
        clearReg     = 1'b1;
        in_cnt_next  = '0;
        out_cnt_next = '0;
        state_next   = MAC;
      end

      MAC: begin
        inCntEn = bufInValid;
        load    = bufInValid;
        if (bufInValid) begin
          // Datapath status and shadow count must agree on which beat is last;
          // on disagreement the datapath still steers the sequence.
          if (mulDone != (in_cnt == IN_LAST)) begin
            err_next = 1'b1;
          end
          if (mulDone) begin
            in_cnt_next = '0;
            state_next  = BIAS;
          end else begin
            in_cnt_next = in_cnt + 1'b1;
          end
        end
      end

      BIAS: begin
        WorB = 1'b1;
        if (bufOutReady) begin
          bufOutWr = 1'b1;
          outCntEn = 1'b1;
          clearReg = 1'b1;
          if (calcDone != (out_cnt == OUT_LAST)) begin
            err_next = 1'b1;
          end
          if (calcDone) begin
            out_cnt_next = '0;
            state_next   = DONE;
          end else begin
            out_cnt_next = out_cnt + 1'b1;
            state_next   = MAC;
          end
        end
      end

      DONE: begin
        done       = 1'b1;
        clear      = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dense_controller.sv
// Bench for dense_controller: a schedule model expands stall patterns into per-cycle control
// expectations; literal cycle numbers pin write/done timing, error stickiness and reset abort.
module tb_dense_controller;

  localparam int NI   = 4;
  localparam int NO   = 3;
  localparam int MAXC = 64;

  localparam logic [9:0] B_BUSY = 10'b1000000000;
  localparam logic [9:0] B_DONE = 10'b0100000000;
  localparam logic [9:0] B_CLR  = 10'b0010000000;
  localparam logic [9:0] B_CREG = 10'b0001000000;
  localparam logic [9:0] B_INC  = 10'b0000100000;
  localparam logic [9:0] B_LOAD = 10'b0000010000;
  localparam logic [9:0] B_WORB = 10'b0000001000;
  localparam logic [9:0] B_WR   = 10'b0000000100;
  localparam logic [9:0] B_OUTC = 10'b0000000010;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic bufInValid = 1'b0;
  logic bufOutReady = 1'b0;
  logic force_mul = 1'b0;
  logic mulDone, calcDone;
  logic busy, done, err, bufOutWr, clear, inCntEn, clearReg, WorB, load, outCntEn;

  logic start_b = 1'b0;
  logic tie1;
  logic busy_b, done_b, err_b, bufOutWr_b, clear_b, inCntEn_b, clearReg_b, WorB_b, load_b, outCntEn_b;

  int n_cmp = 0;
  int n_bad = 0;

  logic       valid_pat [MAXC];
  logic       ready_pat [MAXC];
  logic [9:0] exp_vec   [MAXC];
  logic [3:0] tiny_exp  [7];
  int         exp_len = 0;
  int         wr_q[$];
  int         done_q[$];
  logic       err_c5, err_done;

  int in_idx, out_idx;

  assign tie1 = 1'b1;

  always #5 clk = ~clk;

  dense_controller #(.IN_COUNT(NI), .OUT_COUNT(NO)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .bufInValid(bufInValid), .bufOutReady(bufOutReady), .bufOutWr(bufOutWr),
    .clear(clear), .inCntEn(inCntEn), .clearReg(clearReg), .WorB(WorB), .load(load),
    .outCntEn(outCntEn), .mulDone(mulDone), .calcDone(calcDone)
  );

  dense_controller #(.IN_COUNT(1), .OUT_COUNT(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .err(err_b),
    .bufInValid(bufInValid), .bufOutReady(bufOutReady), .bufOutWr(bufOutWr_b),
    .clear(clear_b), .inCntEn(inCntEn_b), .clearReg(clearReg_b), .WorB(WorB_b), .load(load_b),
    .outCntEn(outCntEn_b), .mulDone(tie1), .calcDone(tie1)
  );

  // Datapath index counters as the controller expects them to behave.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      in_idx  <= 0;
      out_idx <= 0;
    end else if (clear) begin
      in_idx  <= 0;
      out_idx <= 0;
    end else begin
      if (inCntEn)  in_idx  <= (in_idx == NI-1) ? 0 : in_idx + 1;
      if (outCntEn) out_idx <= (out_idx == NO-1) ? 0 : out_idx + 1;
    end
  end

  assign mulDone  = (in_idx == NI-1) || force_mul;
  assign calcDone = (out_idx == NO-1);

  function automatic logic [9:0] outs_a();
    return {busy, done, clear, clearReg, inCntEn, load, WorB, bufOutWr, outCntEn, err};
  endfunction

  task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, expv);
    end
  endtask

  task automatic fill_nominal();
    for (int i = 0; i < MAXC; i++) begin
      valid_pat[i] = 1'b1;
      ready_pat[i] = 1'b1;
    end
  endtask

  // Walk the layer schedule: each beat waits for valid, each write waits for ready.
  task automatic build_model();
    int c;
    for (int i = 0; i < MAXC; i++) exp_vec[i] = '0;
    exp_vec[1] = B_BUSY | B_CLR | B_CREG;
    c = 2;
    for (int k = 0; k < NO; k++) begin
      for (int j = 0; j < NI; j++) begin
        while (!valid_pat[c]) begin
          exp_vec[c] = B_BUSY;
          c++;
        end
        exp_vec[c] = B_BUSY | B_INC | B_LOAD;
        c++;
      end
      while (!ready_pat[c]) begin
        exp_vec[c] = B_BUSY | B_WORB;
        c++;
      end
      exp_vec[c] = B_BUSY | B_WORB | B_WR | B_OUTC | B_CREG;
      c++;
    end
    exp_vec[c] = B_BUSY | B_DONE | B_CLR;
    exp_len = c;
  endtask

  task automatic run(input string name, input bit trace, input bit hold, input int ncyc,
                     input int force_c, input int rst_c);
    wr_q.delete();
    done_q.delete();
    err_c5   = 1'bx;
    err_done = 1'bx;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      #1;
      start       = hold && (c <= exp_len);
      bufInValid  = valid_pat[c];
      bufOutReady = ready_pat[c];
      force_mul   = (c == force_c);
      if (c == rst_c) begin
        #2 rst = 1'b1;
        #1 check({name, "_abort_outs"}, c, 32'(outs_a()), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        break;
      end
      @(negedge clk);
      if (bufOutWr) wr_q.push_back(c);
      if (done) begin
        done_q.push_back(c);
        err_done = err;
      end
      if (c == 5) err_c5 = err;
      if (trace) check({name, "_trace"}, c, 32'(outs_a()), 32'(exp_vec[c]));
    end
    start     = 1'b0;
    force_mul = 1'b0;
  endtask

  task automatic check_events(input string name, input int w0, input int w1, input int w2, input int d0);
    int we[3];
    we[0] = w0;
    we[1] = w1;
    we[2] = w2;
    check({name, "_nwrites"}, 0, 32'(wr_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < wr_q.size(); i++) check({name, "_write_cycle"}, i, 32'(wr_q[i]), 32'(we[i]));
    check({name, "_ndone"}, 0, 32'(done_q.size()), 32'd1);
    if (done_q.size() > 0) check({name, "_done_cycle"}, 0, 32'(done_q[0]), 32'(d0));
  endtask

  initial begin
    tiny_exp[0] = 4'b0000;
    tiny_exp[1] = 4'b1000;
    tiny_exp[2] = 4'b1000;
    tiny_exp[3] = 4'b1010;
    tiny_exp[4] = 4'b1100;
    tiny_exp[5] = 4'b0000;
    tiny_exp[6] = 4'b0000;

    #1 rst = 1'b1;
    #1 check("reset_state", 0, 32'(outs_a()), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Nominal run.
    fill_nominal();
    build_model();
    run("nominal", 1'b1, 1'b0, exp_len + 2, -1, -1);
    check_events("nominal", 6, 11, 16, 17);

    // Two input stalls in the first MAC run.
    fill_nominal();
    valid_pat[3] = 1'b0;
    valid_pat[4] = 1'b0;
    build_model();
    run("in_stall", 1'b1, 1'b0, exp_len + 2, -1, -1);
    check_events("in_stall", 8, 13, 18, 19);

    // Output buffer not ready for three cycles at the second BIAS.
    fill_nominal();
    for (int i = 11; i <= 13; i++) ready_pat[i] = 1'b0;
    build_model();
    run("out_stall", 1'b1, 1'b0, exp_len + 2, -1, -1);
    check_events("out_stall", 6, 14, 19, 20);

    // Early mulDone on the third beat: error flagged, sticky, FSM follows the datapath.
    fill_nominal();
    run("early_mul", 1'b0, 1'b0, 30, 4, -1);
    check("early_mul_err_c5", 5, 32'(err_c5), 32'd1);
    check("early_mul_ndone", 0, 32'(done_q.size()), 32'd1);
    if (done_q.size() > 0) check("early_mul_done_cycle", 0, 32'(done_q[0]), 32'd13);
    check("early_mul_err_at_done", 0, 32'(err_done), 32'd1);
    check("early_mul_err_idle", 0, 32'(err), 32'd1);

    // Next start clears the error (trace expects err=0 from cycle 1).
    fill_nominal();
    build_model();
    run("after_err", 1'b1, 1'b0, exp_len + 2, -1, -1);
    check_events("after_err", 6, 11, 16, 17);

    // Reset during the second output's MAC beats, then a clean restart.
    fill_nominal();
    build_model();
    run("rst_mid", 1'b1, 1'b0, exp_len + 2, -1, 8);
    check("rst_mid_busy", 0, 32'(busy), 32'd0);
    run("rst_restart", 1'b1, 1'b0, exp_len + 2, -1, -1);
    check_events("rst_restart", 6, 11, 16, 17);

    // Start held through the run and at done: exactly one run.
    run("start_hold", 1'b1, 1'b1, exp_len + 2, -1, -1);
    check_events("start_hold", 6, 11, 16, 17);

    // Single-input, single-output instance: done in cycle 4.
    bufInValid  = 1'b1;
    bufOutReady = 1'b1;
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check("tiny_run", c, 32'({busy_b, done_b, bufOutWr_b, err_b}), 32'(tiny_exp[c]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
